seg7_scan_drv: RTL and testbench

Time-multiplexed driver for an N-digit common-anode seven-segment display in the npc board-I/O path. It replaces the single-digit combinational decoder. It latches a packed nibble vector, then scans one digit at a time with a programmable on-time and an all-off dead gap. It decodes each digit in decimal or hex mode, with optional leading-zero blanking and per-digit decimal points. New values take effect only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_decode.sv | 16 +
 rtl/seg7_scan_drv.sv | 190 +++++++++++++++++++
 tb/tb_seg7_scan_drv.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared segment tables and scan-state type for the multiplexed seven-segment driver.
// Patterns are active-low, ordered a..g from bit 6 down to bit 0.
package seg7_pkg;

  typedef enum logic {SHOW, GAP} state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Nibbles 10..15 have no decimal glyph and stay dark.
  localparam logic [6:0] SEG_DEC [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, SEG_BLANK,  SEG_BLANK,
    SEG_BLANK,  SEG_BLANK,  SEG_BLANK,  SEG_BLANK
  };

  localparam logic [6:0] SEG_HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder with decimal/hex selection and forced blanking.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex_mode ? SEG_HEX[nibble] : SEG_DEC[nibble];
    if (blank) seg = SEG_BLANK;
  end

endmodule

// File: rtl/seg7_scan_drv.sv
// Time-multiplexed common-anode seven-segment scanner with tear-free frame-boundary updates.
module seg7_scan_drv
  import seg7_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int DIV    = 1000,
  parameter int DEAD   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_en,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done,
  output logic                  upd_pending
);

  localparam int IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DWELL_MAX = (DIV > DEAD) ? DIV : DEAD;
  localparam int CNT_W     = $clog2(DWELL_MAX + 1);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = (DEAD > 0) ? CNT_W'(DEAD - 1) : '0;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                step, boundary;

  logic [4*DIGITS-1:0] pend_value_q, pend_value_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_hex_q, pend_hex_d;
  logic                pend_blz_q, pend_blz_d;
  logic                pend_vld_q, pend_vld_d;

  logic [4*DIGITS-1:0] disp_value_q, disp_value_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic                disp_hex_q, disp_hex_d;
  logic                disp_blz_q, disp_blz_d;

  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_done_q, frame_done_d;

  logic [3:0]          nib_sel;
  logic                dp_sel;
  logic                upper_zero;
  logic                blank_sel;
  logic [6:0]          dec_seg;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    step    = 1'b0;
    if (state_q == SHOW) begin
      if (cnt_q == SHOW_LAST) begin
        cnt_d = '0;
        if (DEAD == 0) step = 1'b1;
        else           state_d = GAP;
      end
    end else if (DEAD == 0 || cnt_q == GAP_LAST) begin
      cnt_d = '0;
      step  = 1'b1;
    end
    if (step) begin
      state_d = SHOW;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    boundary = step && (idx_q == IDX_LAST);
  end

  // A load on the boundary cycle bypasses the pending set so it is never a frame late.
  always_comb begin
    pend_value_d = pend_value_q;
    pend_dp_d    = pend_dp_q;
    pend_hex_d   = pend_hex_q;
    pend_blz_d   = pend_blz_q;
    pend_vld_d   = pend_vld_q;
    disp_value_d = disp_value_q;
    disp_dp_d    = disp_dp_q;
    disp_hex_d   = disp_hex_q;
    disp_blz_d   = disp_blz_q;
    if (boundary) begin
      pend_vld_d = 1'b0;
      if (load) begin
        disp_value_d = value;
        disp_dp_d    = dp_en;
        disp_hex_d   = hex_mode;
        disp_blz_d   = blank_lz;
      end else if (pend_vld_q) begin
        disp_value_d = pend_value_q;
        disp_dp_d    = pend_dp_q;
        disp_hex_d   = pend_hex_q;
        disp_blz_d   = pend_blz_q;
      end
    end else if (load) begin
      pend_value_d = value;
      pend_dp_d    = dp_en;
      pend_hex_d   = hex_mode;
      pend_blz_d   = blank_lz;
      pend_vld_d   = 1'b1;
    end
  end

  // Outputs are built from next-cycle state so they switch on the same edge as the FSM.
  always_comb begin
    nib_sel    = '0;
    dp_sel     = 1'b0;
    upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nib_sel = disp_value_d[4*i +: 4];
        dp_sel  = disp_dp_d[i];
      end
      if (i >= int'(idx_d) && disp_value_d[4*i +: 4] != 4'd0) upper_zero = 1'b0;
    end
    blank_sel = disp_blz_d && (idx_d != '0) && upper_zero;
  end

  seg7_decode u_decode (
    .nibble   (nib_sel),
    .hex_mode (disp_hex_d),
    .blank    (blank_sel),
    .seg      (dec_seg)
  );

  always_comb begin
    an_d         = '1;
    seg_d        = SEG_BLANK;
    dp_d         = 1'b1;
    frame_done_d = boundary;
    if (state_d == SHOW) begin
      an_d  = ~(DIGITS'(1) << idx_d);
      seg_d = dec_seg;
      dp_d  = ~dp_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= GAP;
      idx_q        <= IDX_LAST;
      cnt_q        <= '0;
      pend_vld_q   <= 1'b0;
      disp_value_q <= '0;
      disp_dp_q    <= '0;
      disp_hex_q   <= 1'b0;
      disp_blz_q   <= 1'b1;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      pend_vld_q   <= pend_vld_d;
      disp_value_q <= disp_value_d;
      disp_dp_q    <= disp_dp_d;
      disp_hex_q   <= disp_hex_d;
      disp_blz_q   <= disp_blz_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Pending payload is only meaningful while pend_vld_q is set, so it carries no reset.
  always_ff @(posedge clk) begin
    pend_value_q <= pend_value_d;
    pend_dp_q    <= pend_dp_d;
    pend_hex_q   <= pend_hex_d;
    pend_blz_q   <= pend_blz_d;
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_done  = frame_done_q;
  assign upd_pending = pend_vld_q;

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Scoreboard bench for seg7_scan_drv with DIGITS=4, DIV=4, DEAD=1 (20-cycle frames).
module tb_seg7_scan_drv;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_en;
  logic        hex_mode;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;
  logic        upd_pending;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  seg7_scan_drv #(.DIGITS(4), .DIV(4), .DEAD(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .value       (value),
    .dp_en       (dp_en),
    .hex_mode    (hex_mode),
    .blank_lz    (blank_lz),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_done  (frame_done),
    .upd_pending (upd_pending)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] model_seg(input logic [3:0] n, input logic hex);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return hex ? 7'b0001000 : 7'b1111111;
      4'hB: return hex ? 7'b1100000 : 7'b1111111;
      4'hC: return hex ? 7'b0110001 : 7'b1111111;
      4'hD: return hex ? 7'b1000010 : 7'b1111111;
      4'hE: return hex ? 7'b0110000 : 7'b1111111;
      default: return hex ? 7'b0111000 : 7'b1111111;
    endcase
  endfunction

  task automatic push_frame(input logic [15:0] v, input logic [3:0] dpe,
                            input logic hex, input logic blz);
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      e.an = ~(4'b0001 << d);
      e.dp = ~dpe[d];
      if (blz && d > 0 && (v >> (4*d)) == 16'h0) e.seg = 7'b1111111;
      else e.seg = model_seg(v[4*d +: 4], hex);
      sb.push_back(e);
    end
  endtask

  // Starts on the negedge where frame_done should be high; ends on the next frame's first negedge.
  task automatic run_frame(input string name);
    exp_t e;
    logic exp_fd;
    for (int d = 0; d < 4; d++) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s scoreboard empty at digit %0d", name, d);
        return;
      end
      e = sb.pop_front();
      for (int c = 0; c < 4; c++) begin
        exp_fd = (d == 0 && c == 0);
        checks++;
        if ({frame_done, an, seg, dp} !== {exp_fd, e.an, e.seg, e.dp}) begin
          errors++;
          $display("FAIL %s d%0d c%0d: got fd=%b an=%b seg=%b dp=%b, want fd=%b an=%b seg=%b dp=%b",
                   name, d, c, frame_done, an, seg, dp, exp_fd, e.an, e.seg, e.dp);
        end
        @(negedge clk);
      end
      checks++;
      if ({frame_done, an, seg, dp} !== {1'b0, 4'b1111, 7'b1111111, 1'b1}) begin
        errors++;
        $display("FAIL %s gap d%0d: got fd=%b an=%b seg=%b dp=%b, want fd=0 an=1111 seg=1111111 dp=1",
                 name, d, frame_done, an, seg, dp);
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_boundary(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL %s boundary timeout: frame_done=%b want 1", name, frame_done);
    end
  endtask

  task automatic load_and_show(input string name, input logic [15:0] v, input logic [3:0] dpe,
                               input logic hex, input logic blz);
    value = v; dp_en = dpe; hex_mode = hex; blank_lz = blz; load = 1'b1;
    push_frame(v, dpe, hex, blz);
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (upd_pending !== 1'b1) begin
      errors++;
      $display("FAIL %s pending after load: got %b want 1", name, upd_pending);
    end
    wait_boundary(name);
    checks++;
    if (upd_pending !== 1'b0) begin
      errors++;
      $display("FAIL %s pending after commit: got %b want 0", name, upd_pending);
    end
    run_frame(name);
  endtask

  task automatic test_reset;
    rst = 1'b1; load = 1'b0; value = '0; dp_en = '0; hex_mode = 1'b0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({an, seg, dp, frame_done, upd_pending} !== {4'b1111, 7'b1111111, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got an=%b seg=%b dp=%b fd=%b pend=%b, want an=1111 seg=1111111 dp=1 fd=0 pend=0",
               an, seg, dp, frame_done, upd_pending);
    end
    push_frame(16'h0000, 4'b0000, 1'b0, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    run_frame("reset_frame");
  endtask

  task automatic test_decimal;
    load_and_show("decimal", 16'h1234, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_hex_blank;
    load_and_show("hex_blank", 16'h00AF, 4'b0010, 1'b1, 1'b1);
  endtask

  task automatic test_invalid_dec;
    load_and_show("invalid_dec", 16'h00C0, 4'b0000, 1'b0, 1'b1);
  endtask

  task automatic test_tear_free;
    push_frame(16'h00C0, 4'b0000, 1'b0, 1'b1);
    fork
      run_frame("tear_old");
      begin
        repeat (6) @(negedge clk);
        value = 16'h1111; dp_en = '0; hex_mode = 1'b0; blank_lz = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (upd_pending !== 1'b1) begin
          errors++;
          $display("FAIL tear_pending: got %b want 1", upd_pending);
        end
        @(negedge clk);
        value = 16'h2222; load = 1'b1;
        push_frame(16'h2222, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        load = 1'b0;
      end
    join
  endtask

  task automatic test_boundary_load;
    fork
      run_frame("tear_new");
      begin
        repeat (19) @(negedge clk);
        checks++;
        if (upd_pending !== 1'b0) begin
          errors++;
          $display("FAIL bload_pre_pending: got %b want 0", upd_pending);
        end
        value = 16'h3333; dp_en = 4'b1001; hex_mode = 1'b0; blank_lz = 1'b0; load = 1'b1;
        push_frame(16'h3333, 4'b1001, 1'b0, 1'b0);
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (upd_pending !== 1'b0) begin
          errors++;
          $display("FAIL bload_pending: got %b want 0", upd_pending);
        end
      end
    join
    run_frame("bload_frame");
  endtask

  task automatic test_reset_midframe;
    value = 16'h4444; dp_en = '0; hex_mode = 1'b0; blank_lz = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (upd_pending !== 1'b1) begin
      errors++;
      $display("FAIL mid_pending: got %b want 1", upd_pending);
    end
    repeat (9) @(negedge clk);
    checks++;
    if (an !== 4'b1011) begin
      errors++;
      $display("FAIL mid_digit2: got an=%b want 1011", an);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({an, seg, dp, frame_done, upd_pending} !== {4'b1111, 7'b1111111, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: got an=%b seg=%b dp=%b fd=%b pend=%b, want an=1111 seg=1111111 dp=1 fd=0 pend=0",
               an, seg, dp, frame_done, upd_pending);
    end
    rst = 1'b0;
    push_frame(16'h0000, 4'b0000, 1'b0, 1'b1);
    @(negedge clk);
    run_frame("restart_frame");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_decimal();
    test_hex_blank();
    test_invalid_dec();
    test_tear_free();
    test_boundary_load();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
